// File: rtl/ysyx_23060332_pkg.sv
// Shared constants and types for the integer write-back path.
package ysyx_23060332_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_EXU,
    GNT_LSU
  } gnt_e;
endpackage

// File: rtl/ysyx_23060332_scoreboard.sv
// Per-register pending bits with RAW query against the in-flight write.
module ysyx_23060332_scoreboard
  import ysyx_23060332_pkg::*;
#(
  parameter int ADDR_W = ysyx_23060332_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_rd,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [ADDR_W-1:0] rs1,
  output logic              rs1_busy,
  output logic              fwd_valid
);
  logic [NUM_REGS-1:0] pending, pending_nxt;

  // Set is applied after clear: the newer instruction owns the register.
  always_comb begin
    pending_nxt = pending;
    if (clr_valid)   pending_nxt[clr_rd]   = 1'b0;
    if (issue_valid) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  assign fwd_valid = wb_valid && (wb_rd == rs1) && (rs1 != '0);
  assign rs1_busy  = pending[rs1] && !fwd_valid;
endmodule

// File: rtl/ysyx_23060332_wb_arb.sv
// Write-back arbiter: LSU-priority with EXU anti-starvation, one-cycle output stage.
module ysyx_23060332_wb_arb
  import ysyx_23060332_pkg::*;
#(
  parameter int DATA_W     = ysyx_23060332_pkg::DATA_W,
  parameter int ADDR_W     = ysyx_23060332_pkg::ADDR_W,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [ADDR_W-1:0] exu_rd,
  input  logic [DATA_W-1:0] exu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1,
  output logic              rs1_busy,
  output logic              fwd_valid,
  output logic [DATA_W-1:0] fwd_data,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata
);
  localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0]  starve_cnt;
  gnt_e              gnt;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (lsu_valid && exu_valid)
        gnt = (starve_cnt == CNT_W'(STARVE_MAX)) ? GNT_EXU : GNT_LSU;
      else if (lsu_valid)
        gnt = GNT_LSU;
      else if (exu_valid)
        gnt = GNT_EXU;
    end
  end

  assign exu_ready = (gnt == GNT_EXU);
  assign lsu_ready = (gnt == GNT_LSU);
  assign win_rd    = (gnt == GNT_EXU) ? exu_rd   : lsu_rd;
  assign win_data  = (gnt == GNT_EXU) ? exu_data : lsu_data;

  // The register file never stalls, so the stage reloads or empties every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      rf_wen     <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
    end else begin
      if (!exu_valid || gnt == GNT_EXU) starve_cnt <= '0;
      else if (gnt == GNT_LSU)          starve_cnt <= starve_cnt + CNT_W'(1);
      rf_wen <= (gnt != GNT_NONE) && (win_rd != '0);
      if (gnt != GNT_NONE) begin
        rf_rd    <= win_rd;
        rf_wdata <= win_data;
      end
    end
  end

  assign fwd_data = rf_wdata;

  ysyx_23060332_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .clr_valid  (gnt != GNT_NONE),
    .clr_rd     (win_rd),
    .wb_valid   (rf_wen),
    .wb_rd      (rf_rd),
    .rs1        (rs1),
    .rs1_busy   (rs1_busy),
    .fwd_valid  (fwd_valid)
  );
endmodule

// File: tb/tb_ysyx_23060332_wb_arb.sv
// Directed + randomized bench for the write-back arbiter against a behavioural model.
module tb_ysyx_23060332_wb_arb;
  localparam int SM = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid, lsu_valid, issue_valid;
  logic        exu_ready, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd, issue_rd, rs1, rf_rd;
  logic [31:0] exu_data, lsu_data, fwd_data, rf_wdata;
  logic        rs1_busy, fwd_valid, rf_wen;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ysyx_23060332_wb_arb #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1),
    .rs1_busy(rs1_busy), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: who wins, which writes are in flight, which regs await a write.
  bit         mdl_on = 1'b0;
  bit         m_wen;
  bit [4:0]   m_rd;
  bit [31:0]  m_data;
  bit [31:0]  m_pend;
  int         m_streak;

  always @(negedge clk) begin
    bit ge, gl, f;
    bit [4:0]  wrd;
    bit [31:0] wd;
    ge = 1'b0;
    gl = 1'b0;
    if (!rst) begin
      if (exu_valid && lsu_valid) begin
        if (m_streak == SM) ge = 1'b1;
        else                gl = 1'b1;
      end else begin
        ge = exu_valid;
        gl = lsu_valid;
      end
    end
    chk("exu_ready", {31'b0, exu_ready}, {31'b0, ge});
    chk("lsu_ready", {31'b0, lsu_ready}, {31'b0, gl});
    if (mdl_on) begin
      f = m_wen && (m_rd == rs1) && (rs1 != 0);
      chk("fwd_valid", {31'b0, fwd_valid}, {31'b0, f});
      chk("rs1_busy", {31'b0, rs1_busy}, {31'b0, (rs1 != 0) && m_pend[rs1] && !f});
      chk("fwd_data", fwd_data, m_data);
      chk("rf_wen", {31'b0, rf_wen}, {31'b0, m_wen});
      chk("rf_rd", {27'b0, rf_rd}, {27'b0, m_rd});
      chk("rf_wdata", rf_wdata, m_data);
    end
    if (rst) begin
      m_wen = 1'b0; m_rd = '0; m_data = '0; m_pend = '0; m_streak = 0;
      mdl_on = 1'b1;
    end else begin
      if (!exu_valid || ge) m_streak = 0;
      else if (gl)          m_streak = m_streak + 1;
      if (ge || gl) begin
        wrd    = ge ? exu_rd : lsu_rd;
        wd     = ge ? exu_data : lsu_data;
        m_rd   = wrd;
        m_data = wd;
        m_wen  = (wrd != 0);
        m_pend[wrd] = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    end
  end

  initial begin
    bit [7:0] gseq_e, gseq_l;
    bit ea, la;
    rst = 1'b1;
    exu_valid = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0;

    // Reset state; readys stay low under reset even with requests present.
    repeat (2) @(posedge clk);
    #1;
    exu_valid = 1; lsu_valid = 1;
    @(negedge clk);
    chk("rst_exu_ready", {31'b0, exu_ready}, 32'd0);
    chk("rst_lsu_ready", {31'b0, lsu_ready}, 32'd0);
    chk("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
    chk("rst_rf_rd", {27'b0, rf_rd}, 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);

    // Single EXU write.
    cyc();
    rst = 0; lsu_valid = 0;
    exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_exu_ready", {31'b0, exu_ready}, 32'd1);
    cyc();
    exu_valid = 0;
    @(negedge clk);
    chk("t1_rf_wen", {31'b0, rf_wen}, 32'd1);
    chk("t1_rf_rd", {27'b0, rf_rd}, 32'd5);
    chk("t1_rf_wdata", rf_wdata, 32'hDEADBEEF);
    cyc();
    @(negedge clk);
    chk("t1_rf_wen_drop", {31'b0, rf_wen}, 32'd0);

    // Continuous contention: L,L,L,E repeating.
    cyc();
    exu_valid = 1; exu_rd = 1; exu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h22;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      gseq_e[i] = exu_ready;
      gseq_l[i] = lsu_ready;
      cyc();
    end
    exu_valid = 0; lsu_valid = 0;
    chk("t2_seq_exu", {24'b0, gseq_e}, 32'h88);
    chk("t2_seq_lsu", {24'b0, gseq_l}, 32'h77);

    // RAW hazard on x7 resolved by an LSU write, forwarded for one cycle.
    issue_valid = 1; issue_rd = 7; rs1 = 7;
    cyc();
    issue_valid = 0;
    @(negedge clk);
    chk("t3_busy_set", {31'b0, rs1_busy}, 32'd1);
    cyc();
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
    @(negedge clk);
    chk("t3_lsu_ready", {31'b0, lsu_ready}, 32'd1);
    cyc();
    lsu_valid = 0;
    @(negedge clk);
    chk("t3_busy_fwd", {31'b0, rs1_busy}, 32'd0);
    chk("t3_fwd_valid", {31'b0, fwd_valid}, 32'd1);
    chk("t3_fwd_data", fwd_data, 32'h1234);
    cyc();
    @(negedge clk);
    chk("t3_fwd_gone", {31'b0, fwd_valid}, 32'd0);
    chk("t3_busy_clr", {31'b0, rs1_busy}, 32'd0);

    // Same-cycle re-issue and write to x9: set wins.
    cyc();
    issue_valid = 1; issue_rd = 9; rs1 = 9;
    cyc();
    exu_valid = 1; exu_rd = 9; exu_data = 32'h99;
    @(negedge clk);
    chk("t4_exu_ready", {31'b0, exu_ready}, 32'd1);
    cyc();
    issue_valid = 0; exu_valid = 0;
    @(negedge clk);
    chk("t4_fwd_valid", {31'b0, fwd_valid}, 32'd1);
    chk("t4_busy_masked", {31'b0, rs1_busy}, 32'd0);
    cyc();
    @(negedge clk);
    chk("t4_busy_kept", {31'b0, rs1_busy}, 32'd1);

    // x0 writes and issues are no-ops.
    cyc();
    exu_valid = 1; exu_rd = 0; exu_data = 32'hFFFFFFFF;
    issue_valid = 1; issue_rd = 0; rs1 = 0;
    @(negedge clk);
    chk("t5_exu_ready", {31'b0, exu_ready}, 32'd1);
    cyc();
    exu_valid = 0; issue_valid = 0;
    @(negedge clk);
    chk("t5_rf_wen", {31'b0, rf_wen}, 32'd0);
    chk("t5_busy_x0", {31'b0, rs1_busy}, 32'd0);
    chk("t5_fwd_x0", {31'b0, fwd_valid}, 32'd0);

    // Reset right after an LSU grant drops the write and the scoreboard.
    cyc();
    issue_valid = 1; issue_rd = 10;
    cyc();
    issue_valid = 0; rs1 = 10;
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h33;
    @(negedge clk);
    chk("t6_lsu_ready", {31'b0, lsu_ready}, 32'd1);
    chk("t6_busy_pre", {31'b0, rs1_busy}, 32'd1);
    cyc();
    lsu_valid = 0; rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("t6_rf_wen", {31'b0, rf_wen}, 32'd0);
    chk("t6_busy_post", {31'b0, rs1_busy}, 32'd0);

    // Random traffic with held requests and occasional resets.
    repeat (2000) begin
      @(negedge clk);
      ea = exu_valid && exu_ready;
      la = lsu_valid && lsu_ready;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 99) == 0);
      if (!exu_valid || ea) begin
        exu_valid = ($urandom_range(0, 3) != 0);
        exu_rd    = 5'($urandom_range(0, 7));
        exu_data  = $urandom;
      end
      if (!lsu_valid || la) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_rd    = 5'($urandom_range(0, 7));
        lsu_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 7));
      rs1         = 5'($urandom_range(0, 7));
    end

    @(posedge clk);
    #1;
    rst = 0; exu_valid = 0; lsu_valid = 0; issue_valid = 0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
